// File: rtl/fns_cac_decoder_4_5.sv
// FNS 4-data/5-redundant TSV decoder: rebuilds the Fibonacci weight map one TSV
// per cycle, skipping faulty TSVs, and returns data, enable map and error flags.
module fns_cac_decoder_4_5 #(
   parameter int DATA_W = 4,
   parameter int N_TSV  = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_TSV-1:0]  tsv_bits,
   input  logic [N_TSV-1:0]  f_flag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic [N_TSV-1:0]  en_flag_out,
   output logic              err_range,
   output logic              err_cover
);

   localparam int WW    = DATA_W + 1;
   localparam int AW    = DATA_W + 2;
   localparam int IDX_W = $clog2(N_TSV);
   localparam int SAT   = 1 << DATA_W;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t             r_state;
   logic [N_TSV-1:0]   r_tsv;
   logic [N_TSV-1:0]   r_flt;
   logic [WW-1:0]      r_a;
   logic [WW-1:0]      r_b;
   logic [AW-1:0]      r_acc;
   logic [IDX_W-1:0]   r_idx;
   logic               r_sat;
   logic [N_TSV-1:0]   r_en;
   logic               r_out_valid;
   logic [DATA_W-1:0]  r_data;
   logic [N_TSV-1:0]   r_en_out;
   logic               r_err_range;
   logic               r_err_cover;

   logic [AW-1:0]      w_w;
   logic               w_err_range;
   logic               w_err_cover;

   assign w_w         = AW'(r_a) + AW'(r_b);
   assign w_err_cover = ~r_sat;
   assign w_err_range = r_sat & (r_acc >= AW'(SAT));

   assign in_ready    = (r_state == IDLE) && rst_n;
   assign out_valid   = r_out_valid;
   assign data_out    = r_data;
   assign en_flag_out = r_en_out;
   assign err_range   = r_err_range;
   assign err_cover   = r_err_cover;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_tsv       <= '0;
         r_flt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_sat       <= 1'b0;
         r_en        <= '0;
         r_out_valid <= 1'b0;
         r_data      <= '0;
         r_en_out    <= '0;
         r_err_range <= 1'b0;
         r_err_cover <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_tsv   <= tsv_bits;
                  r_flt   <= f_flag;
                  r_a     <= '0;
                  r_b     <= WW'(1);
                  r_acc   <= '0;
                  r_idx   <= '0;
                  r_sat   <= 1'b0;
                  r_en    <= '0;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               // Faulty TSVs and everything after saturation stay disabled.
               if (!r_flt[r_idx] && !r_sat) begin
                  if (w_w >= AW'(SAT)) begin
                     r_sat <= 1'b1;
                  end else begin
                     r_en[r_idx] <= 1'b1;
                     if (r_tsv[r_idx]) r_acc <= r_acc + w_w;
                     r_a <= r_b;
                     r_b <= w_w[WW-1:0];
                  end
               end
               if (r_idx == IDX_W'(N_TSV - 1)) r_state <= DONE;
               else                             r_idx   <= r_idx + 1'b1;
            end
            DONE: begin
               // First DONE cycle latches the result; afterwards hold until taken.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_err_cover <= w_err_cover;
                  r_err_range <= w_err_range;
                  r_data      <= (w_err_cover || w_err_range) ? '0 : r_acc[DATA_W-1:0];
                  r_en_out    <= r_en;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
